hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and halt sequencing for a five-stage core.
// Drives the stage-register enables and bubble-insert controls from the
// load-use, jump, halt and memory wait-state conditions.
// Optional build macro HAZARD_CTRL_PERF_EN adds 16-bit saturating event
// counters (stall_cnt, flush_cnt, busy_cnt).
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal issue; handles load-use stalls and jump flushes
// DRAIN   | halt has left EX; older instructions retire, younger squashed
// HALTED  | core stopped, waiting for resume
// RESTART | one cycle refetch with IF/ID and ID/EX flushed
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump,
    input  logic       is_halt_ex,
    input  logic       regwrite_ex,
    input  logic       from_main_mem_ex,
    input  logic [2:0] regwrite_adr_ex,
    input  logic [2:0] rs_id,
    input  logic [2:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic       mem_busy,
    input  logic       resume,
    output logic       en_pc,
    output logic       en_ifid,
    output logic       en_idex,
    output logic       en_exmem,
    output logic       en_memwb,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       flush_memwb,
    output logic       halted,
    output logic       flushed
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [15:0] busy_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HALTED  = 2'd2,
        S_RESTART = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] drain_q, drain_d;
    logic       load_use;
    logic       stall_ev;
    logic       jflush_ev;

    assign load_use = from_main_mem_ex & regwrite_ex &
                      ((use_rs_id & (rs_id == regwrite_adr_ex)) |
                       (use_rt_id & (rt_id == regwrite_adr_ex)));

    // State and drain counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic and all outputs, decoded from state and live inputs.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        halted      = (state_q == S_HALTED);
        flushed     = 1'b0;
        stall_ev    = 1'b0;
        jflush_ev   = 1'b0;

        if (reset) begin
            // Everything frozen and every stage register loading a bubble.
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
            halted      = 1'b0;
        end else if (mem_busy) begin
            // Wait state: freeze the whole pipe, state and counter hold.
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (is_halt_ex) begin
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        en_idex    = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = S_DRAIN;
                        drain_d    = 2'd2;
                    end else if (jump) begin
                        en_pc      = 1'b1;
                        en_ifid    = 1'b1;
                        en_idex    = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        flushed    = 1'b1;
                        jflush_ev  = 1'b1;
                    end else if (load_use) begin
                        en_idex    = 1'b1;
                        flush_idex = 1'b1;
                        en_exmem   = 1'b1;
                        en_memwb   = 1'b1;
                        stall_ev   = 1'b1;
                    end else begin
                        en_pc    = 1'b1;
                        en_ifid  = 1'b1;
                        en_idex  = 1'b1;
                        en_exmem = 1'b1;
                        en_memwb = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Halt moves through MEM and WB; bubbles fill in behind it.
                    en_idex     = 1'b1;
                    flush_idex  = 1'b1;
                    en_exmem    = 1'b1;
                    en_memwb    = 1'b1;
                    flush_exmem = 1'b1;
                    drain_d     = drain_q - 2'd1;
                    if (drain_q <= 2'd1) begin
                        drain_d = 2'd0;
                        state_d = S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (resume) begin
                        state_d = S_RESTART;
                    end
                end
                S_RESTART: begin
                    en_pc      = 1'b1;
                    en_ifid    = 1'b1;
                    en_idex    = 1'b1;
                    en_exmem   = 1'b1;
                    en_memwb   = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    state_d    = S_RUN;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q, busy_cnt_q;

    // Saturating event counters, frozen while the core reports halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            busy_cnt_q  <= 16'd0;
        end else if (!halted) begin
            if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (jflush_ev && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
            if (mem_busy && (busy_cnt_q != 16'hFFFF)) begin
                busy_cnt_q <= busy_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign busy_cnt  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: vector table, directed halt/busy/reset
// sequences and a randomized run against a behavioural pipeline model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       jmp;
        logic       hlt;
        logic       rw;
        logic       fm;
        logic [2:0] wa;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       busy;
        logic       res;
    } in_t;

    typedef struct {
        in_t         i;
        logic [10:0] e;
        string       n;
    } vec_t;

    // {en_pc,en_ifid,en_idex,en_exmem,en_memwb,fl_ifid,fl_idex,fl_exmem,fl_memwb,halted,flushed}
    localparam logic [10:0] O_RST  = 11'b00000_1111_00;
    localparam logic [10:0] O_NORM = 11'b11111_0000_00;
    localparam logic [10:0] O_STL  = 11'b00111_0100_00;
    localparam logic [10:0] O_JMP  = 11'b11111_1100_01;
    localparam logic [10:0] O_DRN  = 11'b00111_0110_00;
    localparam logic [10:0] O_HLT  = 11'b00000_0000_10;
    localparam logic [10:0] O_RSTT = 11'b11111_1100_00;
    localparam logic [10:0] O_BUSY = 11'b00000_0000_00;

    logic       clk = 1'b0;
    logic       reset, jump, is_halt_ex, regwrite_ex, from_main_mem_ex;
    logic [2:0] regwrite_adr_ex, rs_id, rt_id;
    logic       use_rs_id, use_rt_id, mem_busy, resume;
    logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic       flush_ifid, flush_idex, flush_exmem, flush_memwb, halted, flushed;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt, flush_cnt, busy_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: how many drain cycles remain, whether stopped, whether refetching.
    int drain_left = 0;
    bit m_stopped  = 1'b0;
    bit m_refetch  = 1'b0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .jump(jump), .is_halt_ex(is_halt_ex),
        .regwrite_ex(regwrite_ex), .from_main_mem_ex(from_main_mem_ex),
        .regwrite_adr_ex(regwrite_adr_ex), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .mem_busy(mem_busy),
        .resume(resume), .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
        .en_exmem(en_exmem), .en_memwb(en_memwb), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .flush_memwb(flush_memwb), .halted(halted), .flushed(flushed)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy_cnt(busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic r, input logic j, input logic h,
                               input logic w, input logic f, input logic [2:0] a,
                               input logic [2:0] s, input logic [2:0] t,
                               input logic us, input logic ut, input logic b,
                               input logic rz);
        in_t v;
        v.rst = r; v.jmp = j; v.hlt = h; v.rw = w; v.fm = f; v.wa = a;
        v.rs = s; v.rt = t; v.urs = us; v.urt = ut; v.busy = b; v.res = rz;
        return v;
    endfunction

    function automatic logic [10:0] actual();
        return {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                flush_ifid, flush_idex, flush_exmem, flush_memwb, halted, flushed};
    endfunction

    function automatic logic [10:0] model_out(input in_t v);
        bit hazard;
        hazard = v.fm && v.rw && ((v.urs && v.rs == v.wa) || (v.urt && v.rt == v.wa));
        if (v.rst)           return O_RST;
        if (v.busy)          return m_stopped ? O_HLT : O_BUSY;
        if (m_stopped)       return O_HLT;
        if (m_refetch)       return O_RSTT;
        if (drain_left > 0)  return O_DRN;
        if (v.hlt)           return O_STL;
        if (v.jmp)           return O_JMP;
        if (hazard)          return O_STL;
        return O_NORM;
    endfunction

    task automatic model_clock(input in_t v);
        if (v.rst) begin
            drain_left = 0; m_stopped = 1'b0; m_refetch = 1'b0;
        end else if (!v.busy) begin
            if (m_stopped) begin
                if (v.res) begin
                    m_stopped = 1'b0; m_refetch = 1'b1;
                end
            end else if (m_refetch) begin
                m_refetch = 1'b0;
            end else if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) m_stopped = 1'b1;
            end else if (v.hlt) begin
                drain_left = 2;
            end
        end
    endtask

    task automatic drive(input in_t v);
        reset = v.rst; jump = v.jmp; is_halt_ex = v.hlt; regwrite_ex = v.rw;
        from_main_mem_ex = v.fm; regwrite_adr_ex = v.wa; rs_id = v.rs;
        rt_id = v.rt; use_rs_id = v.urs; use_rt_id = v.urt;
        mem_busy = v.busy; resume = v.res;
    endtask

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One clock cycle: drive after negedge, compare against model, then clock model.
    task automatic step(input in_t v, input string nm, output logic [10:0] act);
        @(negedge clk);
        drive(v);
        #1;
        act = actual();
        chk(nm, act, model_out(v));
        @(posedge clk);
        model_clock(v);
    endtask

    vec_t        tbl[12];
    in_t         idle, v;
    logic [10:0] a;

    initial begin
        idle = mk(0,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,0);
        tbl[0]  = '{mk(0,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,0), O_NORM, "idle"};
        tbl[1]  = '{mk(0,0,0,1,1,3'd3,3'd3,3'd0,1,0,0,0), O_STL,  "lu_rs"};
        tbl[2]  = '{mk(0,0,0,1,1,3'd5,3'd1,3'd5,0,1,0,0), O_STL,  "lu_rt"};
        tbl[3]  = '{mk(0,0,0,1,1,3'd3,3'd3,3'd3,0,0,0,0), O_NORM, "no_use"};
        tbl[4]  = '{mk(0,0,0,1,0,3'd3,3'd3,3'd0,1,0,0,0), O_NORM, "not_mem"};
        tbl[5]  = '{mk(0,0,0,0,1,3'd3,3'd3,3'd0,1,0,0,0), O_NORM, "no_wr"};
        tbl[6]  = '{mk(0,1,0,1,1,3'd3,3'd3,3'd0,1,0,0,0), O_JMP,  "jmp_lu"};
        tbl[7]  = '{mk(0,1,1,1,1,3'd3,3'd3,3'd0,1,0,0,0), O_STL,  "halt_pri"};
        tbl[8]  = '{mk(0,1,1,0,0,3'd0,3'd0,3'd0,0,0,1,0), O_BUSY, "busy_pri"};
        tbl[9]  = '{mk(1,1,0,0,0,3'd0,3'd0,3'd0,0,0,0,0), O_RST,  "rst_out"};
        tbl[10] = '{mk(0,0,0,1,1,3'd3,3'd2,3'd3,1,0,0,0), O_NORM, "rs_miss"};
        tbl[11] = '{mk(0,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,1), O_NORM, "resume_run"};

        drive(mk(1,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,0));
        #1;
        chk("reset_state", actual(), O_RST);
        repeat (2) @(posedge clk);

        // Vector table, each applied from RUN with a reset pulse in between.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(tbl[k].i);
            #1;
            chk(tbl[k].n, actual(), tbl[k].e);
            drive(idle);
            reset = 1'b1;
            #1;
            reset = 1'b0;
        end
        drain_left = 0; m_stopped = 1'b0; m_refetch = 1'b0;

        // Load-use: exactly one stall, then the pipe moves again.
        step(mk(0,0,0,1,1,3'd3,3'd3,3'd0,1,0,0,0), "lu_stall", a);
        step(mk(0,0,0,0,0,3'd0,3'd3,3'd0,1,0,0,0), "lu_after", a);
        chk("lu_after_en", a, O_NORM);

        // Halt at T, drain T+1..T+2, halted T+3, resume T+5, restart T+6, run T+7.
        step(mk(0,0,1,0,0,3'd0,3'd0,3'd0,0,0,0,0), "halt_T", a);
        step(idle, "halt_T1", a); chk("drain_T1", a, O_DRN);
        step(idle, "halt_T2", a); chk("drain_T2", a, O_DRN);
        step(idle, "halt_T3", a); chk("halted_T3", a, O_HLT);
        step(mk(0,1,0,1,1,3'd1,3'd1,3'd0,1,0,0,0), "halt_T4", a); chk("halted_ign", a, O_HLT);
        step(mk(0,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,1), "halt_T5", a); chk("halted_T5", a, O_HLT);
        step(idle, "halt_T6", a); chk("restart_T6", a, O_RSTT);
        step(idle, "halt_T7", a); chk("run_T7", a, O_NORM);

        // Busy during drain freezes everything; halted arrives three cycles late.
        step(mk(0,0,1,0,0,3'd0,3'd0,3'd0,0,0,0,0), "bhalt_T", a);
        step(idle, "bdrain1", a); chk("bdrain1_o", a, O_DRN);
        for (int k = 0; k < 3; k++) begin
            step(mk(0,0,0,0,0,3'd0,3'd0,3'd0,0,0,1,1), "bbusy", a);
            chk("bbusy_o", a, O_BUSY);
        end
        step(idle, "bdrain2", a); chk("bdrain2_o", a, O_DRN);
        step(idle, "bhalted", a); chk("bhalted_o", a, O_HLT);

        // Reset while halted: immediate reset outputs, then normal run.
        step(mk(1,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,0), "rst_halt", a);
        chk("rst_halt_o", a, O_RST);
        step(idle, "rst_rel", a); chk("rst_rel_o", a, O_NORM);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            v.rst  = ($urandom_range(99) < 1);
            v.jmp  = ($urandom_range(99) < 15);
            v.hlt  = ($urandom_range(99) < 5);
            v.rw   = ($urandom_range(99) < 70);
            v.fm   = ($urandom_range(99) < 50);
            v.wa   = 3'($urandom_range(3));
            v.rs   = 3'($urandom_range(3));
            v.rt   = 3'($urandom_range(3));
            v.urs  = $urandom_range(1);
            v.urt  = $urandom_range(1);
            v.busy = ($urandom_range(99) < 15);
            v.res  = ($urandom_range(99) < 20);
            step(v, "rand", a);
        end

`ifdef HAZARD_CTRL_PERF_EN
        drive(mk(1,0,0,0,0,3'd0,3'd0,3'd0,0,0,0,0));
        @(negedge clk);
        drive(mk(0,0,0,1,1,3'd3,3'd3,3'd0,1,0,0,0));
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", {stall_cnt[10:0]}, 11'h7FF);
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL stall_cnt: got %h expected ffff", stall_cnt);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (stall_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL stall_clr: got %h expected 0000", stall_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
